c17_bist_ctrl: RTL

C17_BIST_CTRL -- requirements
Module: c17_bist_ctrl

---
 rtl/c17_bist_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/c17_bist_ctrl.sv
// BIST controller for the ISCAS-85 C17 circuit: a 5-bit LFSR drives the
// circuit inputs and an 8-bit MISR compacts its responses into a signature.
module c17_bist_ctrl #(
    parameter int PAT_COUNT = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] golden,
    output logic [4:0] cut_in,
    input  logic [1:0] cut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CMP  = 2'd2
    } state_t;

    localparam logic [4:0] LFSR_SEED = 5'b00001;
    localparam logic [7:0] MISR_POLY = 8'h1D;
    localparam logic [4:0] CNT_LAST  = 5'(PAT_COUNT - 1);

    state_t     r_state;
    logic [4:0] r_lfsr;
    logic [7:0] r_misr;
    logic [4:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic       w_run;

    // Fibonacci LFSR for x^5 + x^3 + 1
    function automatic logic [4:0] lfsr_next(input logic [4:0] l);
        return {l[3:0], l[4] ^ l[2]};
    endfunction

    function automatic logic [7:0] misr_next(input logic [7:0] m, input logic [1:0] d);
        return {m[6:0], 1'b0} ^ (m[7] ? MISR_POLY : 8'h00) ^ {6'b0, d};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lfsr  <= LFSR_SEED;
            r_misr  <= 8'h00;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_lfsr  <= LFSR_SEED;
                        r_misr  <= 8'h00;
                        r_cnt   <= 5'd0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_lfsr <= lfsr_next(r_lfsr);
                    r_misr <= misr_next(r_misr, cut_out);
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_CMP;
                        r_done  <= 1'b1;
                    end
                end
                S_CMP: begin
                    // signature is frozen here; the compare result persists in IDLE
                    r_pass  <= (r_misr == golden);
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_run     = (r_state == S_RUN);
    assign cut_in    = w_run ? r_lfsr : 5'b00000;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_misr;

endmodule
